// File: rtl/logic_pkg.sv
// Shared opcode definitions for the bitwise logic blocks and later ALU blocks.
package logic_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_AND  = 3'b000;
  localparam opcode_t OP_OR   = 3'b001;
  localparam opcode_t OP_NOT  = 3'b010;
  localparam opcode_t OP_NAND = 3'b011;
  localparam opcode_t OP_NOR  = 3'b100;
  localparam opcode_t OP_XOR  = 3'b101;
  localparam opcode_t OP_XNOR = 3'b110;
  localparam opcode_t OP_PASS = 3'b111;

  // Opcodes whose result depends on operand a only.
  function automatic logic op_is_unary(opcode_t op);
    return (op == OP_NOT) || (op == OP_PASS);
  endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Command/result bus of logic_unit_pipe; slave is the block, master is the source/consumer side.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import logic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  opcode_t          op;
  logic             acc_en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, op, acc_en, a, b, out_ready,
    input  in_ready, out_valid, y, zero, parity, done_cnt
  );

  modport slave (
    input  in_valid, op, acc_en, a, b, out_ready,
    output in_ready, out_valid, y, zero, parity, done_cnt
  );

endinterface

// File: rtl/logic_op_core.sv
// Combinational eight-way bitwise gate: the primitive-gate function used in stage 2.
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with accumulate mode, result flags and completion counter.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_unit_pipe_if.slave   bus
);

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  opcode_t          op1_q, op1_d;
  logic             acc_en1_q, acc_en1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             s2_ready, s1_ready;
  logic             accept, s2_load, complete;
  logic [WIDTH-1:0] eff_a, res;

  assign s2_ready = !v2_q || bus.out_ready;
  assign s1_ready = !v1_q || s2_ready;
  assign accept   = bus.in_valid && s1_ready;
  assign s2_load  = v1_q && s2_ready;
  assign complete = v2_q && bus.out_ready;

  // acc always holds the previous transaction's result, so substituting here
  // at the S2 load chains back-to-back accumulates without a hazard.
  assign eff_a = acc_en1_q ? acc_q : a1_q;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (op1_q),
    .a  (eff_a),
    .b  (b1_q),
    .y  (res)
  );

  always_comb begin
    v1_d       = v1_q;
    v2_d       = v2_q;
    op1_d      = op1_q;
    acc_en1_d  = acc_en1_q;
    a1_d       = a1_q;
    b1_d       = b1_q;
    y_d        = y_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    acc_d      = acc_q;
    done_cnt_d = done_cnt_q;

    if (accept) begin
      v1_d      = 1'b1;
      op1_d     = bus.op;
      acc_en1_d = bus.acc_en;
      a1_d      = bus.a;
      b1_d      = bus.b;
    end else if (s2_load) begin
      v1_d = 1'b0;
    end

    if (s2_load) begin
      v2_d     = 1'b1;
      y_d      = res;
      zero_d   = (res == '0);
      parity_d = ^res;
      acc_d    = res;
    end else if (complete) begin
      v2_d = 1'b0;
    end

    if (complete) begin
      done_cnt_d = done_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b1;
      parity_q   <= 1'b0;
      acc_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      acc_q      <= acc_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // S1 payload is qualified by v1, so it needs no reset.
  always_ff @(posedge clk) begin
    op1_q     <= op1_d;
    acc_en1_q <= acc_en1_d;
    a1_q      <= a1_d;
    b1_q      <= b1_d;
  end

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = v2_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_logic_unit_pipe;
  import logic_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  int         acc_cyc[$];
  int         out_cyc[$];
  logic [7:0] out_y[$];
  logic       out_z[$];
  logic       out_p[$];

  always @(posedge clk) cyc = cyc + 1;

  // Handshakes seen at the falling edge are the ones that fire on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (bus.out_valid && bus.out_ready) begin
        out_y.push_back(bus.y);
        out_z.push_back(bus.zero);
        out_p.push_back(bus.parity);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    acc_cyc.delete();
    out_cyc.delete();
    out_y.delete();
    out_z.delete();
    out_p.delete();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    clear_q();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic send(input logic [2:0] o, input logic ae, input logic [7:0] av, input logic [7:0] bv);
    logic ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.acc_en   = ae;
    bus.a        = av;
    bus.b        = bv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 200; i++) begin
      if (out_y.size() >= n) break;
      @(negedge clk);
    end
    chk("drain_count", 32'(out_y.size()), 32'(n));
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] exp_op[8]  = '{8'h48, 8'hDE, 8'h35, 8'hB7, 8'h21, 8'h96, 8'h69, 8'hCA};
  logic [7:0] exp_acc[4] = '{8'h01, 8'h03, 8'h07, 8'hF8};
  logic [7:0] exp_bp[4]  = '{8'h48, 8'hFF, 8'hAA, 8'hC3};

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_AND;
    bus.acc_en    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset and idle
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_zero",      32'(bus.zero),      32'd1);
    chk("rst_parity",    32'(bus.parity),    32'd0);
    chk("rst_y",         32'(bus.y),         32'd0);
    chk("rst_done_cnt",  32'(bus.done_cnt),  32'd0);
    @(posedge clk);
    #1;

    // All opcodes, a=CA b=5C, streamed back to back
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 8'hCA, 8'h5C);
    wait_out(8);
    for (int i = 0; i < 8 && i < out_y.size(); i++) begin
      chk($sformatf("op%0d_y", i),       32'(out_y[i]), 32'(exp_op[i]));
      chk($sformatf("op%0d_zero", i),    32'(out_z[i]), 32'd0);
      chk($sformatf("op%0d_parity", i),  32'(out_p[i]), 32'(^exp_op[i]));
      chk($sformatf("op%0d_latency", i), 32'(out_cyc[i] - acc_cyc[i]), 32'd2);
    end
    settle();
    chk("op_done_cnt", 32'(bus.done_cnt), 32'd8);
    clear_q();
    @(posedge clk);
    #1;

    // Zero flag and an odd-parity result
    send(OP_XOR, 1'b0, 8'h3F, 8'h3F);
    send(OP_AND, 1'b0, 8'h07, 8'h01);
    wait_out(2);
    if (out_y.size() >= 2) begin
      chk("zero_y",      32'(out_y[0]), 32'h00);
      chk("zero_flag",   32'(out_z[0]), 32'd1);
      chk("zero_parity", 32'(out_p[0]), 32'd0);
      chk("odd_y",       32'(out_y[1]), 32'h01);
      chk("odd_zero",    32'(out_z[1]), 32'd0);
      chk("odd_parity",  32'(out_p[1]), 32'd1);
    end
    settle();
    chk("zero_done_cnt", 32'(bus.done_cnt), 32'd10);
    clear_q();
    @(posedge clk);
    #1;

    // Accumulate chain at full throughput
    send(OP_OR,  1'b0, 8'h01, 8'h01);
    send(OP_OR,  1'b1, 8'h00, 8'h02);
    send(OP_OR,  1'b1, 8'h00, 8'h04);
    send(OP_XOR, 1'b1, 8'h00, 8'hFF);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_y.size(); i++)
      chk($sformatf("acc%0d_y", i), 32'(out_y[i]), 32'(exp_acc[i]));

    // Backpressure: five stalled cycles while four inputs are offered
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        send(OP_AND, 1'b0, 8'hCA, 8'h5C);
        send(OP_OR,  1'b0, 8'h0F, 8'hF0);
        send(OP_XOR, 1'b0, 8'hA5, 8'h0F);
        send(OP_NOT, 1'b0, 8'h3C, 8'h00);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            chk($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_y", i),     32'(bus.y),         32'h48);
            chk($sformatf("bp_hold%0d_ready", i), 32'(bus.in_ready),  32'd0);
          end
        end
        chk("bp_accepts_stalled", 32'(acc_cyc.size()), 32'd2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_out(4);
    for (int i = 0; i < 4 && i < out_y.size(); i++)
      chk($sformatf("bp%0d_y", i), 32'(out_y[i]), 32'(exp_bp[i]));
    settle();
    chk("bp_done_cnt", 32'(bus.done_cnt), 32'd4);
    @(posedge clk);
    #1;

    // Reset with two transactions in flight, then first acc_en after reset sees acc=0
    send(OP_OR,  1'b0, 8'hF0, 8'h0F);
    send(OP_AND, 1'b0, 8'hCA, 8'h5C);
    rst_n = 1'b0;
    clear_q();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_out_valid_after", 32'(bus.out_valid), 32'd0);
    chk("midrst_no_output",       32'(out_y.size()),  32'd0);
    chk("midrst_done_cnt",        32'(bus.done_cnt),  32'd0);
    @(posedge clk);
    #1;
    send(OP_OR, 1'b1, 8'h77, 8'h12);
    wait_out(1);
    if (out_y.size() >= 1) chk("acc_after_rst_y", 32'(out_y[0]), 32'h12);
    @(posedge clk);
    #1;

    // Counter wrap: 17 completions on a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) send(OP_PASS, 1'b0, 8'(i), 8'h00);
    wait_out(17);
    settle();
    chk("wrap_done_cnt", 32'(bus.done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
